rst_seq: RTL and testbench



---
 rtl/rst_seq.sv | 202 ++++++++++++++++++++
 tb/tb_rst_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq -- reset sequencer for the Wishbone clock domain.
//
// Waits for a stable DCM lock, then releases the per-subsystem resets one at
// a time (index 0 first) with a fixed spacing. In RUN, a software soft-reset
// request first asks the masters to quiesce, waits for every domain to go
// idle (or gives up after a timeout), holds all resets, and then repeats the
// staged release. Losing lock at any point puts every domain back in reset.
//
// Ports:
//   wb_clk_i   in   1     sole clock, rising edge
//   wb_rst_i   in   1     synchronous active-high reset
//   clk_locked in   1     raw DCM lock (asynchronous, synchronized here)
//   soft_req   in   1     one-cycle soft-reset request
//   idle_i     in   NRST  per-domain "nothing outstanding" flags
//   rst_o      out  NRST  per-domain active-high resets (registered)
//   quiesce_o  out  1     ask masters to stop issuing cycles (registered)
//   busy_o     out  1     state is not RUN (decoded from state register)
//   soft_done  out  1     one-cycle pulse when a soft sequence reaches RUN
//   timeout_o  out  1     sticky: quiesce wait timed out
//   lock_lost  out  1     sticky: lock dropped in RUN or QUIESCE
// ---------------------------------------------------------------------------
module rst_seq #(
    parameter int NRST      = 3,
    parameter int STAGE_CYC = 16,
    parameter int QTIMEOUT  = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            clk_locked,
    input  logic            soft_req,
    input  logic [NRST-1:0] idle_i,
    output logic [NRST-1:0] rst_o,
    output logic            quiesce_o,
    output logic            busy_o,
    output logic            soft_done,
    output logic            timeout_o,
    output logic            lock_lost
);

    localparam int CNT_MAX = (STAGE_CYC > QTIMEOUT) ? STAGE_CYC : QTIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(NRST) + 1;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);
    localparam logic [CNT_W-1:0] QTO_LAST   = CNT_W'(QTIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NRST - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    localparam logic [2:0] S_WAIT_LOCK = 3'd0;
    localparam logic [2:0] S_RELEASE   = 3'd1;
    localparam logic [2:0] S_RUN       = 3'd2;
    localparam logic [2:0] S_QUIESCE   = 3'd3;
    localparam logic [2:0] S_ASSERT    = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic [NRST-1:0]  r_rst;
    logic             r_quiesce;
    logic             r_soft_done;
    logic             r_timeout;
    logic             r_lock_lost;
    logic             r_soft_pending;   // current release was started by a soft sequence
    logic             w_all_idle;

    assign w_all_idle = &idle_i;

    // NOTE: every register here is assigned with <= so that all flops sample
    // the same pre-edge values; blocking assignments would make the result
    // depend on statement order inside the block.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_lock_meta    <= 1'b0;
            r_lock_s       <= 1'b0;
            r_rst          <= '1;
            r_quiesce      <= 1'b0;
            r_soft_done    <= 1'b0;
            r_timeout      <= 1'b0;
            r_lock_lost    <= 1'b0;
            r_soft_pending <= 1'b0;
        end else begin
            // Two-flop synchronizer for the asynchronous DCM lock.
            r_lock_meta <= clk_locked;
            r_lock_s    <= r_lock_meta;
            r_soft_done <= 1'b0;

            case (r_state)
                S_WAIT_LOCK: begin
                    // Lock must read high for STAGE_CYC consecutive cycles.
                    if (!r_lock_s) begin
                        r_cnt <= '0;
                    end else if (r_cnt == STAGE_LAST) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_RELEASE: begin
                    if (!r_lock_s) begin
                        // Lock loss here is not reported; it just restarts.
                        r_state        <= S_WAIT_LOCK;
                        r_rst          <= '1;
                        r_cnt          <= '0;
                        r_soft_pending <= 1'b0;
                    end else if (r_cnt == STAGE_LAST) begin
                        r_cnt <= '0;
                        r_idx <= r_idx + IDX_ONE;
                        // Decode idx against each bit rather than indexing,
                        // so idx may be wider than the domain vector needs.
                        for (int k = 0; k < NRST; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_rst[k] <= 1'b0;
                            end
                        end
                        if (r_idx == IDX_LAST) begin
                            r_state        <= S_RUN;
                            r_soft_done    <= r_soft_pending;
                            r_soft_pending <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_RUN: begin
                    // Lock loss wins over a simultaneous soft request.
                    if (!r_lock_s) begin
                        r_state     <= S_WAIT_LOCK;
                        r_rst       <= '1;
                        r_cnt       <= '0;
                        r_lock_lost <= 1'b1;
                    end else if (soft_req) begin
                        r_state   <= S_QUIESCE;
                        r_quiesce <= 1'b1;
                        r_cnt     <= '0;
                    end
                end

                S_QUIESCE: begin
                    if (!r_lock_s) begin
                        r_state     <= S_WAIT_LOCK;
                        r_rst       <= '1;
                        r_quiesce   <= 1'b0;
                        r_cnt       <= '0;
                        r_lock_lost <= 1'b1;
                    end else if (w_all_idle || (r_cnt == QTO_LAST)) begin
                        // Idle takes precedence: timeout only flags when the
                        // domains never went idle.
                        r_state   <= S_ASSERT;
                        r_rst     <= '1;
                        r_quiesce <= 1'b0;
                        r_cnt     <= '0;
                        if (!w_all_idle) begin
                            r_timeout <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_ASSERT: begin
                    if (!r_lock_s) begin
                        r_state        <= S_WAIT_LOCK;
                        r_cnt          <= '0;
                        r_soft_pending <= 1'b0;
                    end else if (r_cnt == STAGE_LAST) begin
                        r_state        <= S_RELEASE;
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_soft_pending <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state <= S_WAIT_LOCK;
                    r_rst   <= '1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign rst_o     = r_rst;
    assign quiesce_o = r_quiesce;
    assign busy_o    = (r_state != S_RUN);
    assign soft_done = r_soft_done;
    assign timeout_o = r_timeout;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq -- self-checking bench for rst_seq (NRST=3, STAGE_CYC=16,
// QTIMEOUT=1024).
//
// A timestamp-based reference model records the edge at which each phase
// began and derives the expected outputs from those edge numbers; a compare
// process checks every output on every falling edge. Directed stimulus is
// laid out on an absolute edge timeline, with literal expectations at the
// key edges of each scenario.
// ---------------------------------------------------------------------------
module tb_rst_seq;

    localparam int NRST  = 3;
    localparam int STAGE = 16;
    localparam int QTO   = 1024;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic            clk_locked;
    logic            soft_req;
    logic [NRST-1:0] idle_i;
    logic [NRST-1:0] rst_o;
    logic            quiesce_o;
    logic            busy_o;
    logic            soft_done;
    logic            timeout_o;
    logic            lock_lost;

    rst_seq #(
        .NRST      (NRST),
        .STAGE_CYC (STAGE),
        .QTIMEOUT  (QTO)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .clk_locked (clk_locked),
        .soft_req   (soft_req),
        .idle_i     (idle_i),
        .rst_o      (rst_o),
        .quiesce_o  (quiesce_o),
        .busy_o     (busy_o),
        .soft_done  (soft_done),
        .timeout_o  (timeout_o),
        .lock_lost  (lock_lost)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;   // number of rising edges seen so far

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: cycle %0d got 'h%0h expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_WAIT, M_REL, M_RUN, M_QUI, M_ASRT} mode_e;

    mode_e mode    = M_WAIT;
    bit    lk_h [0:4095];   // clk_locked sampled at each edge
    bit    rh_h [0:4095];   // wb_rst_i sampled at each edge
    int    stable  = -1;    // edge at which the current run of lock_s=1 began
    int    e_rel   = 0;     // RELEASE entry edge
    int    s_qui   = 0;     // soft_req edge
    int    a_asrt  = 0;     // ASSERT entry edge
    bit    pend    = 1'b0;
    bit    m_sd    = 1'b0;
    bit    m_to    = 1'b0;
    bit    m_ll    = 1'b0;

    function automatic logic [NRST-1:0] exp_rst();
        logic [NRST-1:0] v;
        v = '0;
        case (mode)
            M_WAIT, M_ASRT: v = '1;
            M_REL: begin
                for (int k = 0; k < NRST; k++) begin
                    v[k] = (cyc < e_rel + STAGE * (k + 1));
                end
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    initial begin
        bit ls;
        forever begin
            @(posedge wb_clk_i);
            cyc++;
            lk_h[cyc] = clk_locked;
            rh_h[cyc] = wb_rst_i;
            if (wb_rst_i) begin
                mode   = M_WAIT;
                stable = -1;
                pend   = 1'b0;
                m_sd   = 1'b0;
                m_to   = 1'b0;
                m_ll   = 1'b0;
            end else begin
                // lock_s is clk_locked two edges back, unless a reset edge
                // cleared the synchronizer in between.
                ls   = (cyc >= 3) && !rh_h[cyc-1] && !rh_h[cyc-2] && lk_h[cyc-2];
                m_sd = 1'b0;
                case (mode)
                    M_WAIT: begin
                        if (ls) begin
                            if (stable < 0) stable = cyc;
                            if (cyc - stable == STAGE - 1) begin
                                mode  = M_REL;
                                e_rel = cyc;
                            end
                        end else begin
                            stable = -1;
                        end
                    end
                    M_REL: begin
                        if (!ls) begin
                            mode = M_WAIT; stable = -1; pend = 1'b0;
                        end else if (cyc - e_rel == STAGE * NRST) begin
                            mode = M_RUN; m_sd = pend; pend = 1'b0;
                        end
                    end
                    M_RUN: begin
                        if (!ls) begin
                            mode = M_WAIT; stable = -1; m_ll = 1'b1;
                        end else if (soft_req) begin
                            mode = M_QUI; s_qui = cyc;
                        end
                    end
                    M_QUI: begin
                        if (!ls) begin
                            mode = M_WAIT; stable = -1; m_ll = 1'b1;
                        end else if (&idle_i) begin
                            mode = M_ASRT; a_asrt = cyc;
                        end else if (cyc - s_qui == QTO) begin
                            mode = M_ASRT; a_asrt = cyc; m_to = 1'b1;
                        end
                    end
                    M_ASRT: begin
                        if (!ls) begin
                            mode = M_WAIT; stable = -1; pend = 1'b0;
                        end else if (cyc - a_asrt == STAGE) begin
                            mode = M_REL; e_rel = cyc; pend = 1'b1;
                        end
                    end
                    default: mode = M_WAIT;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (cyc > 0) begin
                check("cycle",
                      {rst_o, quiesce_o, busy_o, soft_done, timeout_o, lock_lost},
                      {exp_rst(), mode == M_QUI, mode != M_RUN, m_sd, m_to, m_ll});
            end
        end
    end

    // Advance to the falling edge that follows rising edge n.
    task automatic at(input int n);
        while (cyc < n) @(negedge wb_clk_i);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        wb_rst_i   = 1'b1;
        clk_locked = 1'b1;
        soft_req   = 1'b0;
        idle_i     = 3'b111;

        // Power-up: reset on edges 1..4, lock_s high from edge 7,
        // RELEASE entered at edge 22, domains released at 38/54/70.
        at(4);    wb_rst_i = 1'b0;
        at(21);   check("pu_rst_wait",  8'(rst_o), 8'h7);
                  check("pu_busy_wait", 8'(busy_o), 8'h1);
        at(37);   check("pu_rst_37",    8'(rst_o), 8'h7);
        at(38);   check("pu_rst_38",    8'(rst_o), 8'h6);
        at(54);   check("pu_rst_54",    8'(rst_o), 8'h4);
        at(69);   check("pu_busy_69",   8'(busy_o), 8'h1);
        at(70);   check("pu_rst_70",    8'(rst_o), 8'h0);
                  check("pu_busy_70",   8'(busy_o), 8'h0);
                  check("pu_sd_70",     8'(soft_done), 8'h0);

        // Clean soft reset: S=76, ASSERT at 77, RELEASE at 93, RUN at 141.
        // Requests at 80 (ASSERT) and 100 (RELEASE) must be ignored.
        at(75);   soft_req = 1'b1;
        at(76);   soft_req = 1'b0;
                  check("sr_quiesce", 8'(quiesce_o), 8'h1);
                  check("sr_busy",    8'(busy_o), 8'h1);
                  check("sr_rst_76",  8'(rst_o), 8'h0);
        at(77);   check("sr_rst_77",  8'(rst_o), 8'h7);
                  check("sr_qui_77",  8'(quiesce_o), 8'h0);
        at(79);   soft_req = 1'b1;
        at(80);   soft_req = 1'b0;
        at(92);   check("sr_hold_92", 8'(rst_o), 8'h7);
        at(99);   soft_req = 1'b1;
        at(100);  soft_req = 1'b0;
        at(109);  check("sr_rst_109", 8'(rst_o), 8'h6);
        at(140);  check("sr_sd_140",  8'(soft_done), 8'h0);
        at(141);  check("sr_rst_141", 8'(rst_o), 8'h0);
                  check("sr_sd_141",  8'(soft_done), 8'h1);
                  check("sr_to_141",  8'(timeout_o), 8'h0);
        at(142);  check("sr_sd_142",  8'(soft_done), 8'h0);

        // Quiesce timeout: S=151, domain 2 never idle, timeout at 1175.
        at(150);  soft_req = 1'b1; idle_i = 3'b011;
        at(151);  soft_req = 1'b0;
                  check("to_qui_151", 8'(quiesce_o), 8'h1);
        at(1174); check("to_rst_1174", 8'(rst_o), 8'h0);
                  check("to_qui_1174", 8'(quiesce_o), 8'h1);
                  check("to_flag_1174", 8'(timeout_o), 8'h0);
        at(1175); check("to_rst_1175", 8'(rst_o), 8'h7);
                  check("to_flag_1175", 8'(timeout_o), 8'h1);
                  check("to_qui_1175", 8'(quiesce_o), 8'h0);
                  idle_i = 3'b111;
        at(1239); check("to_rst_1239", 8'(rst_o), 8'h0);
                  check("to_busy_1239", 8'(busy_o), 8'h0);
                  check("to_sd_1239",  8'(soft_done), 8'h1);
                  check("to_flag_1239", 8'(timeout_o), 8'h1);

        // Lock loss during QUIESCE: lock sampled low from 1256, seen at 1258.
        // Lock back at 1261 -> lock_s at 1263 -> RELEASE 1278 -> RUN 1326.
        at(1245); soft_req = 1'b1; idle_i = 3'b011;
        at(1246); soft_req = 1'b0;
        at(1255); clk_locked = 1'b0;
        at(1257); check("ll_rst_1257", 8'(rst_o), 8'h0);
                  check("ll_qui_1257", 8'(quiesce_o), 8'h1);
                  check("ll_flag_1257", 8'(lock_lost), 8'h0);
        at(1258); check("ll_rst_1258", 8'(rst_o), 8'h7);
                  check("ll_qui_1258", 8'(quiesce_o), 8'h0);
                  check("ll_flag_1258", 8'(lock_lost), 8'h1);
                  check("ll_busy_1258", 8'(busy_o), 8'h1);
                  idle_i = 3'b111;
        at(1260); clk_locked = 1'b1;
        at(1277); check("ll_rst_1277", 8'(rst_o), 8'h7);
        at(1294); check("ll_rst_1294", 8'(rst_o), 8'h6);
        at(1326); check("ll_rst_1326", 8'(rst_o), 8'h0);
                  check("ll_busy_1326", 8'(busy_o), 8'h0);
                  check("ll_sd_1326", 8'(soft_done), 8'h0);
                  check("ll_flag_1326", 8'(lock_lost), 8'h1);
                  check("ll_to_1326", 8'(timeout_o), 8'h1);

        // Global reset clears sticky flags; then a 3-cycle lock glitch in
        // WAIT_LOCK restarts the count: lock_s high again at 1346 -> E=1361.
        at(1330); wb_rst_i = 1'b1;
        at(1331); check("gr_rst", 8'(rst_o), 8'h7);
                  check("gr_qui", 8'(quiesce_o), 8'h0);
                  check("gr_busy", 8'(busy_o), 8'h1);
                  check("gr_to", 8'(timeout_o), 8'h0);
                  check("gr_ll", 8'(lock_lost), 8'h0);
                  check("gr_sd", 8'(soft_done), 8'h0);
        at(1334); wb_rst_i = 1'b0;
        at(1340); clk_locked = 1'b0;
        at(1343); clk_locked = 1'b1;
        at(1360); check("gl_rst_1360", 8'(rst_o), 8'h7);
        at(1377); check("gl_rst_1377", 8'(rst_o), 8'h6);
                  check("gl_ll_1377", 8'(lock_lost), 8'h0);

        // Global reset in the middle of RELEASE.
        at(1385); check("mr_rst_1385", 8'(rst_o), 8'h6);
                  wb_rst_i = 1'b1;
        at(1386); check("mr_rst_1386", 8'(rst_o), 8'h7);
                  check("mr_busy_1386", 8'(busy_o), 8'h1);
                  check("mr_qui_1386", 8'(quiesce_o), 8'h0);
        at(1387); wb_rst_i = 1'b0;
        at(1404); check("mr_rst_1404", 8'(rst_o), 8'h7);
        at(1421); check("mr_rst_1421", 8'(rst_o), 8'h6);
        at(1453); check("mr_rst_1453", 8'(rst_o), 8'h0);
                  check("mr_busy_1453", 8'(busy_o), 8'h0);

        at(1460);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
